// File: rtl/pa_pkg.sv
// rtl/pa_pkg.sv - shared widths, instruction field layout and decode helper for the fetch unit
package pa_pkg;

  localparam int INSTR_W    = 32;
  localparam int ADDR_W     = 16;

  localparam int BRANCH_BIT = 31;
  localparam int FORMAT_BIT = 30;
  localparam int OPCODE_LSB = 23;
  localparam int OPCODE_W   = 7;
  localparam int PRIM_LSB   = 18;
  localparam int PRIM_W     = 5;
  localparam int SEC_LSB    = 2;
  localparam int SEC_W      = 16;

  typedef enum logic [1:0] {
    FUNC_ARITH  = 2'd0,
    FUNC_LDST   = 2'd1,
    FUNC_BRANCH = 2'd2,
    FUNC_REG    = 2'd3
  } func_type_e;

  typedef struct packed {
    logic [INSTR_W-1:0] word;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  typedef struct packed {
    logic                is_branch;
    logic                instr_format;
    logic [OPCODE_W-1:0] opcode;
    logic [PRIM_W-1:0]   prim_operand;
    logic [SEC_W-1:0]    sec_operand;
  } instr_fields_t;

  // Bits 1:0 of the word are reserved and deliberately not decoded.
  function automatic instr_fields_t decode_word(input logic [INSTR_W-1:0] word);
    instr_fields_t f;
    f.is_branch    = word[BRANCH_BIT];
    f.instr_format = word[FORMAT_BIT];
    f.opcode       = word[OPCODE_LSB +: OPCODE_W];
    f.prim_operand = word[PRIM_LSB +: PRIM_W];
    f.sec_operand  = word[SEC_LSB +: SEC_W];
    return f;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry {word, pc} FIFO with push, pop, flush and occupancy
module fetch_queue
  import pa_pkg::*;
(
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o,
  output logic         empty_o
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  // Push and pop together on a full queue is legal; push on full without pop is prevented upstream.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with 2-deep queue, redirect flush; FETCH_PERF_COUNTERS_EN adds fetch/squash counters
module fetch_unit
  import pa_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirectAddr_i,
  output logic                imemReq_o,
  output logic [ADDR_W-1:0]   imemAddr_o,
  input  logic [INSTR_W-1:0]  imemData_i,
  output logic                enable_o,
  output logic                isBranch_o,
  output logic                instructionFormat_o,
  output logic [OPCODE_W-1:0] opcode_o,
  output logic [PRIM_W-1:0]   primOperand_o,
  output logic [SEC_W-1:0]    secOperand_o,
  output logic [ADDR_W-1:0]   pc_o
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]         fetchCount_o,
  output logic [15:0]         squashCount_o
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              out_valid_q, out_valid_d;
  instr_fields_t     out_fields_q, out_fields_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;

  logic              imem_req;
  logic [1:0]        outstanding;
  logic              pop_out;
  logic              q_push, q_pop, q_empty;
  logic [1:0]        q_count;
  fetch_entry_t      q_head, resp_entry, head_entry;

  fetch_queue u_queue (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .flush_i     (redirect_i),
    .push_i      (q_push),
    .push_data_i (resp_entry),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .count_o     (q_count),
    .empty_o     (q_empty)
  );

  // Queued entries plus the one response still on the bus bound new requests.
  assign outstanding = q_count + {1'b0, inflight_q};
  assign imem_req    = enable_i && !redirect_i && !reset_i && (outstanding < 2'd2);
  assign imemReq_o   = imem_req;
  assign imemAddr_o  = pc_q;

  // An arriving response bypasses the empty queue so decode sees it two cycles after the request.
  always_comb begin
    resp_entry      = '0;
    resp_entry.word = imemData_i;
    resp_entry.pc   = inflight_pc_q;
    head_entry      = q_empty ? resp_entry : q_head;
    pop_out         = (!q_empty || inflight_q) && !stall_i && !redirect_i;
    q_pop           = pop_out && !q_empty;
    q_push          = inflight_q && !redirect_i && !(pop_out && q_empty);
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = inflight_pc_q;
    out_valid_d   = 1'b0;
    out_fields_d  = out_fields_q;
    out_pc_d      = out_pc_q;
    if (redirect_i) begin
      pc_d = redirectAddr_i;
    end else begin
      if (imem_req) begin
        pc_d          = pc_q + 16'd1;
        inflight_pc_d = pc_q;
      end
      if (pop_out) begin
        out_valid_d  = 1'b1;
        out_fields_d = decode_word(head_entry.word);
        out_pc_d     = head_entry.pc;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_valid_q   <= 1'b0;
      out_fields_q  <= '0;
      out_pc_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      out_valid_q   <= out_valid_d;
      out_fields_q  <= out_fields_d;
      out_pc_q      <= out_pc_d;
    end
  end

  assign enable_o            = out_valid_q;
  assign isBranch_o          = out_fields_q.is_branch;
  assign instructionFormat_o = out_fields_q.instr_format;
  assign opcode_o            = out_fields_q.opcode;
  assign primOperand_o       = out_fields_q.prim_operand;
  assign secOperand_o        = out_fields_q.sec_operand;
  assign pc_o                = out_pc_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [15:0] squash_count_q, squash_count_d;

  always_comb begin
    fetch_count_d  = fetch_count_q;
    squash_count_d = squash_count_q;
    if (out_valid_d && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (redirect_i && (squash_count_q != 16'hFFFF)) begin
      squash_count_d = squash_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fetch_count_q  <= '0;
      squash_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign fetchCount_o  = fetch_count_q;
  assign squashCount_o = squash_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a counting reference model
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        reset_i, enable_i, stall_i, redirect_i;
  logic [15:0] redirectAddr_i;
  logic        imemReq_o;
  logic [15:0] imemAddr_o;
  logic [31:0] imemData_i;
  logic        enable_o, isBranch_o, instructionFormat_o;
  logic [6:0]  opcode_o;
  logic [4:0]  primOperand_o;
  logic [15:0] secOperand_o, pc_o;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetchCount_o;
  logic [15:0] squashCount_o;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clock_i             (clk),
    .reset_i             (reset_i),
    .enable_i            (enable_i),
    .stall_i             (stall_i),
    .redirect_i          (redirect_i),
    .redirectAddr_i      (redirectAddr_i),
    .imemReq_o           (imemReq_o),
    .imemAddr_o          (imemAddr_o),
    .imemData_i          (imemData_i),
    .enable_o            (enable_o),
    .isBranch_o          (isBranch_o),
    .instructionFormat_o (instructionFormat_o),
    .opcode_o            (opcode_o),
    .primOperand_o       (primOperand_o),
    .secOperand_o        (secOperand_o),
    .pc_o                (pc_o)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .fetchCount_o        (fetchCount_o),
    .squashCount_o       (squashCount_o)
`endif
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          iss = 0;
  int          pop = 0;
  int          fetch_total = 0;
  int          squash_total = 0;
  logic        armed = 1'b0;
  logic        exp_strobe = 1'b0;
  logic        prev_reset = 1'b0;
  logic        last_req = 1'b0;
  logic [15:0] last_addr = '0;
  logic [15:0] exp_pc = RST_PC;
  logic [15:0] exp_req = RST_PC;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'h0013) return 32'h8AC6_0008;
    return {a ^ 16'hC35A, a * 16'd7 + 16'h1234};
  endfunction

  // One clock: drive inputs at negedge, memory answers last cycle's request, then check and advance the model.
  task automatic step(input logic rst, input logic en, input logic stl, input logic redir,
                      input logic [15:0] raddr);
    logic [31:0] w;
    logic        want_req;
    logic        next_strobe;
    @(negedge clk);
    reset_i        = rst;
    enable_i       = en;
    stall_i        = stl;
    redirect_i     = redir;
    redirectAddr_i = raddr;
    imemData_i     = last_req ? mem_word(last_addr) : $urandom();
    #1;
    if (armed) begin
      check_eq("strobe", enable_o, exp_strobe);
      if (prev_reset) begin
        check_eq("reset_pc_o", pc_o, 0);
        check_eq("reset_fields", {isBranch_o, instructionFormat_o, opcode_o, primOperand_o, secOperand_o}, 0);
      end
      if (enable_o) begin
        pop++;
        fetch_total++;
        w = mem_word(exp_pc);
        check_eq("pc_o", pc_o, exp_pc);
        check_eq("fields", {isBranch_o, instructionFormat_o, opcode_o, primOperand_o, secOperand_o},
                 {w[31], w[30], w[29:23], w[22:18], w[17:2]});
        exp_pc = exp_pc + 16'd1;
      end
      check_eq("outstanding_le2", ((iss - pop) <= 2), 1);
      want_req = !rst && en && !redir && ((iss - pop) < 2);
      check_eq("imem_req", imemReq_o, want_req);
      if (imemReq_o) check_eq("imem_addr", imemAddr_o, exp_req);
`ifdef FETCH_PERF_COUNTERS_EN
      check_eq("fetch_count", fetchCount_o, fetch_total);
      check_eq("squash_count", squashCount_o, squash_total);
`endif
    end
    next_strobe = !rst && !redir && !stl && ((iss - pop) > 0);
    if (rst) begin
      iss = 0; pop = 0; exp_pc = RST_PC; exp_req = RST_PC;
      fetch_total = 0; squash_total = 0;
    end else if (redir) begin
      iss = 0; pop = 0; exp_pc = raddr; exp_req = raddr;
      squash_total++;
    end else if (imemReq_o) begin
      iss++;
      exp_req = exp_req + 16'd1;
    end
    last_req   = imemReq_o;
    last_addr  = imemAddr_o;
    exp_strobe = next_strobe;
    prev_reset = rst;
    if (rst) armed = 1'b1;
  endtask

  initial begin
    logic        seen;
    logic        have_prev;
    logic [15:0] prev_req_addr;
    logic        r_rst, r_redir;
    logic [15:0] r_addr;

    reset_i = 1'b1; enable_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    redirectAddr_i = '0; imemData_i = '0;

    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // Startup latency and steady one-per-cycle stream from RESET_PC.
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0, 0);
      if (i <= 3) begin
        check_eq("startup_req", imemReq_o, 1);
        check_eq("startup_addr", imemAddr_o, RST_PC + 16'(i - 1));
      end
      if (i >= 3) begin
        check_eq("startup_en", enable_o, 1);
        check_eq("startup_pc", pc_o, RST_PC + 16'(i - 3));
      end
      if (i == 6) begin
        check_eq("dec_branch", isBranch_o, 1);
        check_eq("dec_format", instructionFormat_o, 0);
        check_eq("dec_opcode", opcode_o, 21);
        check_eq("dec_prim", primOperand_o, 17);
        check_eq("dec_sec", secOperand_o, 16'h8002);
      end
    end

    // Five-cycle stall mid-stream.
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 1, 0, 0);
      if (k >= 2) check_eq("stall_en_low", enable_o, 0);
    end
    for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0);

    // Redirect with a full queue under stall.
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 16'h0200);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, 0, 0);
      if (enable_o && !seen) begin
        check_eq("redir_first_pc", pc_o, 16'h0200);
        seen = 1'b1;
      end
    end
    check_eq("redir_seen", seen, 1);

    // PC wrap at 16'hFFFF.
    step(0, 1, 0, 1, 16'hFFFE);
    seen = 1'b0; have_prev = 1'b0; prev_req_addr = '0;
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, 0, 0);
      if (imemReq_o) begin
        if (have_prev && prev_req_addr == 16'hFFFF) begin
          check_eq("wrap_addr", imemAddr_o, 16'h0000);
          seen = 1'b1;
        end
        have_prev = 1'b1;
        prev_req_addr = imemAddr_o;
      end
    end
    check_eq("wrap_seen", seen, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      r_rst   = ($urandom_range(0, 199) == 0);
      r_redir = !r_rst && ($urandom_range(0, 15) == 0);
      r_addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom());
      step(r_rst, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0), r_redir, r_addr);
    end

`ifdef FETCH_PERF_COUNTERS_EN
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 60 && fetch_total < 10; k++) begin
      step(0, 1, ((fetch_total + int'(exp_strobe)) >= 10), 0, 0);
    end
    step(0, 0, 1, 1, 16'h0040);
    step(0, 0, 1, 1, 16'h0080);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_eq("perf_fetch10", fetchCount_o, 10);
    check_eq("perf_squash2", squashCount_o, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, word address loaded into PC on reset.
REQ-002 clock_i  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_i  in  1  synchronous, active-high reset.
REQ-004 enable_i  in  1  run permission; low = issue no new memory requests.
REQ-005 stall_i  in  1  downstream decode not accepting; high = present no instruction.
REQ-006 redirect_i  in  1  taken branch; flush and refetch from redirectAddr_i.
REQ-007 redirectAddr_i  in  16  redirect target word address.
REQ-008 imemReq_o  out  1  instruction memory read strobe.
REQ-009 imemAddr_o  out  16  read word address, valid with imemReq_o.
REQ-010 imemData_i  in  32  read data, valid exactly one cycle after imemReq_o.
REQ-011 enable_o  out  1  one-cycle strobe: fields below hold a new instruction.
REQ-012 isBranch_o  out  1  word bit 31.
REQ-013 instructionFormat_o  out  1  word bit 30; 1 = register-immediate, 0 = register-register.
REQ-014 opcode_o  out  7  word bits 29:23.
REQ-015 primOperand_o  out  5  word bits 22:18.
REQ-016 secOperand_o  out  16  word bits 17:2; bits 1:0 reserved, ignored.
REQ-017 pc_o  out  16  address of instruction presented with enable_o.

Function
REQ-018 PC: 16-bit word address, +1 per issued request, wraps 16'hFFFF -> 16'h0000.
REQ-019 Queue: 2-entry FIFO of {word, pc}; request issued in a cycle only if enable_i, no redirect_i, and (occupancy + in-flight) < 2.
REQ-020 Response captured into queue tail the cycle after its request unless discarded (REQ-023).
REQ-021 Output registered: if queue non-empty and !stall_i, head popped, fields and pc_o loaded, enable_o <= 1; otherwise enable_o <= 0 and fields/pc_o hold.
REQ-022 Latency: request at cycle N, capture N+1, enable_o high N+2 when queue was empty and stall_i low; sustained throughput one instruction per cycle.
REQ-023 redirect_i: same edge flushes queue, marks in-flight response for discard, PC <= redirectAddr_i, enable_o <= 0; first new request the following cycle.
REQ-024 Priority: reset_i > redirect_i > stall_i; redirect with stall still flushes.
REQ-025 Simultaneous push and pop on full queue: legal, occupancy unchanged; push on full without pop cannot occur (REQ-019).
REQ-026 enable_i low: in-flight response still captured; queue drains per stall_i.

Reset
REQ-027 On reset_i: PC <= RESET_PC, queue empty, discard flag clear, imemReq_o = 0, enable_o = 0, all field outputs and pc_o = 0.
REQ-028 Reset mid-operation drops in-flight response; first request earliest cycle after reset_i deasserts.

Configuration
REQ-029 Macro FETCH_PERF_COUNTERS_EN defined: extra outputs fetchCount_o (32, +1 per enable_o strobe) and squashCount_o (16, +1 per redirect_i cycle), both saturating, zero on reset.
REQ-030 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package pa_pkg: instruction word width (32), field bit positions/widths, address width (16), function type constants (arith 0, load/store 1, branch 2, reg 3).
REQ-032 One sub-module fetch_queue: 2-entry FIFO with push, pop, flush, occupancy.

Verification
REQ-033 Reset with RESET_PC=16'h0010, enable_i=1, stall_i=0 -> imemAddr_o 0x0010,0x0011,0x0012 consecutive; enable_o every cycle from third cycle, pc_o matching.
REQ-034 imemData_i=32'h8AC6_0008 -> isBranch_o=1, instructionFormat_o=0, opcode_o=21, primOperand_o=17, secOperand_o=16'h8002.
REQ-035 stall_i high 5 cycles mid-stream -> at most 2 requests outstanding, enable_o low throughout, on release pc_o resumes in order with no gap or duplicate.
REQ-036 redirect_i with redirectAddr_i=16'h0200 while queue full -> no instruction from old stream appears; next enable_o carries pc_o=0x0200.
REQ-037 PC at 16'hFFFF -> next imemAddr_o 16'h0000.
REQ-038 With FETCH_PERF_COUNTERS_EN: 10 strobes and 2 redirects -> fetchCount_o=10, squashCount_o=2.
